irs_block_readout_seq: RTL and testbench
========================================

# irs_block_readout_seq

Initiator side of the IRS block read-address handshake. It accepts a request of {start block, block count} and walks consecutive block addresses modulo 512. For each block it strobes the read-address responder, fires one Wilkinson ramp-start pulse once the address is reached, and advances on the responder's acknowledge. It sits between the event readout controller and the IRS block read-address module.

## Interface
- TIMEOUT_CYCLES, 4095: per-block watchdog limit in cycles, measured from strobe assertion to acknowledge. Legal range 1..65535.
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- req_start_i  in  9  first block address.
- req_count_i  in  9  number of blocks minus 1, so 0..511 encodes 1..512 blocks.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  high only in IDLE.
- abort_i  in  1  single-cycle abort request.
- raddr_o  out  9  block address presented to the responder.
- raddr_stb_o  out  1  address strobe, held high until acknowledged.
- raddr_reached_i  in  1  responder has reached raddr_o (level).
- raddr_ack_i  in  1  responder reached raddr_o and the ramp completed (one-cycle pulse).
- ramp_start_o  out  1  one-cycle Wilkinson ramp start pulse.
- blk_done_o  out  1  one-cycle pulse per completed block.
- blk_addr_o  out  9  address of the completed block, valid with blk_done_o.
- done_o  out  1  one-cycle pulse when the request ends (normal, abort, or timeout).
- aborted_o  out  1  sticky; set when a request ends by abort; cleared on the next accept.
- timeout_o  out  1  sticky; set when a request ends by timeout; cleared on the next accept.

## Operation
- States are IDLE, WAIT_REACHED, WAIT_ACK and FINISH.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i: latch address=req_start_i and remaining=req_count_i, assert raddr_stb_o, clear the sticky flags, go to WAIT_REACHED.
- WAIT_REACHED:
  - On raddr_reached_i: pulse ramp_start_o, go to WAIT_ACK.
  - raddr_reached_i already high on the first cycle after strobe is legal and is handled the same way.
- WAIT_ACK, on raddr_ack_i:
  - Pulse blk_done_o with blk_addr_o=raddr_o.
  - If remaining==0 or an abort is pending: drop raddr_stb_o and go to FINISH.
  - Otherwise: raddr_o<=raddr_o+1 (9-bit wrap, 511 becomes 0), remaining<=remaining-1, keep raddr_stb_o high, go to WAIT_REACHED.
- FINISH: pulse done_o, go to IDLE.
- Abort:
  - abort_i in WAIT_REACHED/WAIT_ACK sets abort_pending.
  - The strobe is never withdrawn mid-block; the current block completes, then FINISH runs and aborted_o is set.
  - abort_i in IDLE/FINISH is ignored.
- Watchdog:
  - Counter clears on every strobe (new address) and counts while in WAIT_REACHED/WAIT_ACK.
  - When it reaches TIMEOUT_CYCLES before ack: drop raddr_stb_o, set timeout_o, go to FINISH, no blk_done_o.
  - Timeout takes precedence over a simultaneous abort; an ack in the same cycle takes precedence over timeout.
- Reset, including mid-request:
  - State→IDLE.
  - raddr_o=0, raddr_stb_o=0, every pulse output 0, aborted_o=0, timeout_o=0, req_ready_o=1.

## Timing
- Request accepted at edge T: raddr_stb_o=1 and raddr_o valid from T+1.
- raddr_reached_i first seen high at cycle R: ramp_start_o high for cycle R+1 only.
- raddr_ack_i high at cycle A:
  - blk_done_o and blk_addr_o at A+1.
  - If a next block exists: the new raddr_o is presented with the strobe still high at A+1. This is the first cycle the responder resamples its strobe, so blocks run back-to-back with no gap.
  - Otherwise: raddr_stb_o=0 at A+1, done_o at A+2, req_ready_o at A+3.
- All outputs are registered; nothing depends combinationally on an input.
- raddr_ack_i outside WAIT_ACK and raddr_reached_i outside WAIT_REACHED are ignored.

## Structure
- Shared package irs_readout_pkg holds:
  - the state enum
  - IRS_ADDR_W=9
  - IRS_NUM_BLOCKS=512
- One sub-module, irs_readout_watchdog: a loadable up-counter with clear, enable and an expiry flag, parameterised by TIMEOUT_CYCLES.

## Test plan
- Single block: start=5, count=0; the responder model reaches after 4 cycles and acks 10 cycles later. Expect:
  - one ramp_start_o
  - blk_done_o with blk_addr_o=5
  - done_o two cycles after the ack
  - no flags set.
- Wrap: start=510, count=2. Expect raddr_o sequence 510, 511, 0, three ramp_start_o pulses, and the strobe held continuously high across all three acks.
- Abort: abort_i during WAIT_REACHED of block 2 of start=20, count=7. Expect:
  - block 21 completes
  - no block 22 strobe
  - done_o and aborted_o=1.
- Timeout: TIMEOUT_CYCLES=16 and the responder never acks. Expect:
  - raddr_stb_o drops after 16 cycles
  - timeout_o=1, done_o, no blk_done_o
  - the next request clears timeout_o.
- Reset mid-request: assert rst_n_i low during WAIT_ACK, asynchronously between edges. Expect every output at its reset value immediately and req_ready_o=1 after release.
- Corner case: ack and timeout expiry in the same cycle on the last block. Expect blk_done_o, done_o and timeout_o=0.

Source files
------------

// File: rtl/irs_readout_pkg.sv
// -----------------------------------------------------------------------------
// irs_readout_pkg
// Shared definitions for the IRS block readout initiator:
//   - IRS_ADDR_W / IRS_NUM_BLOCKS : block address width and block count
//   - irs_rd_state_e              : readout sequencer states
//   - irs_next_addr()             : next block address with modulo-512 wrap
// -----------------------------------------------------------------------------
package irs_readout_pkg;

  localparam int IRS_ADDR_W     = 9;
  localparam int IRS_NUM_BLOCKS = 512;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_REACHED = 2'd1,
    ST_WAIT_ACK     = 2'd2,
    ST_FINISH       = 2'd3
  } irs_rd_state_e;

  // Address after 'addr', wrapping from the last block back to block 0.
  function automatic logic [IRS_ADDR_W-1:0] irs_next_addr(input logic [IRS_ADDR_W-1:0] addr);
    logic [IRS_ADDR_W:0] w_sum;
    w_sum = {1'b0, addr} + {{IRS_ADDR_W{1'b0}}, 1'b1};
    if (w_sum == (IRS_ADDR_W + 1)'(IRS_NUM_BLOCKS)) begin
      return {IRS_ADDR_W{1'b0}};
    end else begin
      return w_sum[IRS_ADDR_W-1:0];
    end
  endfunction

endpackage

// File: rtl/irs_readout_watchdog.sv
// -----------------------------------------------------------------------------
// irs_readout_watchdog
// Loadable 16-bit up-counter used as the per-block watchdog.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   clr_i          : clear the count to zero (highest priority)
//   load_i         : load load_val_i
//   load_val_i     : value to load
//   en_i           : count enable
//   expired_o      : high in the enabled cycle that completes TIMEOUT_CYCLES
//                    counted cycles since the last clear
// -----------------------------------------------------------------------------
module irs_readout_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        en_i,
  output logic        expired_o
);

  // The count holds (cycles enabled - 1) in the current enabled cycle, so the
  // limit is reached when the register equals TIMEOUT_CYCLES-1 while enabled.
  localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  logic [15:0] r_cnt;

  // Counter register: clear beats load beats increment.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= 16'd0;
    end else if (clr_i) begin
      r_cnt <= 16'd0;
    end else if (load_i) begin
      r_cnt <= load_val_i;
    end else if (en_i) begin
      r_cnt <= r_cnt + 16'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign expired_o = en_i & (r_cnt == LP_LAST);

endmodule

// File: rtl/irs_block_readout_seq.sv
// -----------------------------------------------------------------------------
// irs_block_readout_seq
// Initiator side of the IRS block read-address handshake. Walks consecutive
// block addresses (mod 512) starting at req_start_i for req_count_i+1 blocks.
//   clk_i, rst_n_i       : clock, asynchronous active-low reset
//   req_start_i/_count_i : first block, block count minus one
//   req_valid_i/ready_o  : request handshake (ready only while idle)
//   abort_i              : ends the request after the current block
//   raddr_o/raddr_stb_o  : address and strobe to the responder
//   raddr_reached_i      : responder is at raddr_o (level)
//   raddr_ack_i          : block finished (pulse)
//   ramp_start_o         : Wilkinson ramp start pulse
//   blk_done_o/blk_addr_o: per-block completion pulse and its address
//   done_o               : request finished pulse
//   aborted_o/timeout_o  : sticky end-cause flags, cleared on next accept
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module irs_block_readout_seq
  import irs_readout_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [IRS_ADDR_W-1:0] req_start_i,
  input  logic [IRS_ADDR_W-1:0] req_count_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  abort_i,
  output logic [IRS_ADDR_W-1:0] raddr_o,
  output logic                  raddr_stb_o,
  input  logic                  raddr_reached_i,
  input  logic                  raddr_ack_i,
  output logic                  ramp_start_o,
  output logic                  blk_done_o,
  output logic [IRS_ADDR_W-1:0] blk_addr_o,
  output logic                  done_o,
  output logic                  aborted_o,
  output logic                  timeout_o
);

  irs_rd_state_e         r_state, w_state_n;
  logic [IRS_ADDR_W-1:0] r_raddr, w_raddr_n;
  logic [IRS_ADDR_W-1:0] r_remain, w_remain_n;
  logic [IRS_ADDR_W-1:0] r_blk_addr, w_blk_addr_n;
  logic                  r_stb, w_stb_n;
  logic                  r_ramp, w_ramp_n;
  logic                  r_blk_done, w_blk_done_n;
  logic                  r_done, w_done_n;
  logic                  r_aborted, w_aborted_n;
  logic                  r_timeout, w_timeout_n;
  logic                  r_abort_pend, w_abort_pend_n;
  logic                  r_ready, w_ready_n;
  logic                  w_wd_clr, w_wd_en, w_wd_expired;

  // The watchdog runs only while a strobe is outstanding.
  assign w_wd_en = (r_state == ST_WAIT_REACHED) || (r_state == ST_WAIT_ACK);

  irs_readout_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clr_i      (w_wd_clr),
    .load_i     (1'b0),
    .load_val_i (16'd0),
    .en_i       (w_wd_en),
    .expired_o  (w_wd_expired)
  );

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    w_state_n      = r_state;
    w_raddr_n      = r_raddr;
    w_remain_n     = r_remain;
    w_blk_addr_n   = r_blk_addr;
    w_stb_n        = r_stb;
    w_ramp_n       = 1'b0;
    w_blk_done_n   = 1'b0;
    w_done_n       = 1'b0;
    w_aborted_n    = r_aborted;
    w_timeout_n    = r_timeout;
    w_abort_pend_n = r_abort_pend;
    w_wd_clr       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // req_ready_o lags entry to IDLE by one cycle; accept only when it is shown.
        if (r_ready && req_valid_i) begin
          w_raddr_n      = req_start_i;
          w_remain_n     = req_count_i;
          w_stb_n        = 1'b1;
          w_aborted_n    = 1'b0;
          w_timeout_n    = 1'b0;
          w_abort_pend_n = 1'b0;
          w_wd_clr       = 1'b1;
          w_state_n      = ST_WAIT_REACHED;
        end else begin
          w_stb_n = 1'b0;
        end
      end

      ST_WAIT_REACHED: begin
        w_abort_pend_n = r_abort_pend | abort_i;
        if (w_wd_expired) begin
          w_stb_n     = 1'b0;
          w_timeout_n = 1'b1;
          w_state_n   = ST_FINISH;
        end else if (raddr_reached_i) begin
          w_ramp_n  = 1'b1;
          w_state_n = ST_WAIT_ACK;
        end else begin
          w_state_n = ST_WAIT_REACHED;
        end
      end

      ST_WAIT_ACK: begin
        w_abort_pend_n = r_abort_pend | abort_i;
        // An ack landing in the expiry cycle still completes the block.
        if (raddr_ack_i) begin
          w_blk_done_n = 1'b1;
          w_blk_addr_n = r_raddr;
          if ((r_remain == {IRS_ADDR_W{1'b0}}) || w_abort_pend_n) begin
            w_stb_n     = 1'b0;
            w_aborted_n = w_abort_pend_n;
            w_state_n   = ST_FINISH;
          end else begin
            // Strobe stays high so the next block starts with no idle gap.
            w_raddr_n  = irs_next_addr(r_raddr);
            w_remain_n = r_remain - {{(IRS_ADDR_W-1){1'b0}}, 1'b1};
            w_wd_clr   = 1'b1;
            w_state_n  = ST_WAIT_REACHED;
          end
        end else if (w_wd_expired) begin
          w_stb_n     = 1'b0;
          w_timeout_n = 1'b1;
          w_state_n   = ST_FINISH;
        end else begin
          w_state_n = ST_WAIT_ACK;
        end
      end

      ST_FINISH: begin
        w_done_n       = 1'b1;
        w_stb_n        = 1'b0;
        w_abort_pend_n = 1'b0;
        w_state_n      = ST_IDLE;
      end

      default: begin
        w_stb_n   = 1'b0;
        w_state_n = ST_IDLE;
      end
    endcase

    w_ready_n = (r_state == ST_IDLE) && (w_state_n == ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= ST_IDLE;
      r_raddr      <= {IRS_ADDR_W{1'b0}};
      r_remain     <= {IRS_ADDR_W{1'b0}};
      r_blk_addr   <= {IRS_ADDR_W{1'b0}};
      r_stb        <= 1'b0;
      r_ramp       <= 1'b0;
      r_blk_done   <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_timeout    <= 1'b0;
      r_abort_pend <= 1'b0;
      r_ready      <= 1'b1;
    end else begin
      r_state      <= w_state_n;
      r_raddr      <= w_raddr_n;
      r_remain     <= w_remain_n;
      r_blk_addr   <= w_blk_addr_n;
      r_stb        <= w_stb_n;
      r_ramp       <= w_ramp_n;
      r_blk_done   <= w_blk_done_n;
      r_done       <= w_done_n;
      r_aborted    <= w_aborted_n;
      r_timeout    <= w_timeout_n;
      r_abort_pend <= w_abort_pend_n;
      r_ready      <= w_ready_n;
    end
  end

  assign req_ready_o  = r_ready;
  assign raddr_o      = r_raddr;
  assign raddr_stb_o  = r_stb;
  assign ramp_start_o = r_ramp;
  assign blk_done_o   = r_blk_done;
  assign blk_addr_o   = r_blk_addr;
  assign done_o       = r_done;
  assign aborted_o    = r_aborted;
  assign timeout_o    = r_timeout;

endmodule

// File: tb/tb_irs_block_readout_seq.sv
// -----------------------------------------------------------------------------
// tb_irs_block_readout_seq
// Directed bench for irs_block_readout_seq with a reactive responder model.
// The DUT runs with a 16-cycle watchdog so timeout cases stay short.
// -----------------------------------------------------------------------------
module tb_irs_block_readout_seq;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [8:0] req_start_i;
  logic [8:0] req_count_i;
  logic       req_valid_i;
  logic       req_ready_o;
  logic       abort_i;
  logic [8:0] raddr_o;
  logic       raddr_stb_o;
  logic       raddr_reached_i;
  logic       raddr_ack_i;
  logic       ramp_start_o;
  logic       blk_done_o;
  logic [8:0] blk_addr_o;
  logic       done_o;
  logic       aborted_o;
  logic       timeout_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations collected by run_resp.
  int         obs_ramp, obs_ramp_cyc, obs_blk, obs_blk_cyc, obs_done, obs_done_cyc;
  int         obs_ready_cyc, obs_stb_hi, obs_stb_rise, obs_nsaddr;
  logic [8:0] obs_baddr [0:7];
  logic [8:0] obs_saddr [0:7];

  always #5 clk_i = ~clk_i;

  irs_block_readout_seq #(.TIMEOUT_CYCLES(16)) u_dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .req_start_i     (req_start_i),
    .req_count_i     (req_count_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .abort_i         (abort_i),
    .raddr_o         (raddr_o),
    .raddr_stb_o     (raddr_stb_o),
    .raddr_reached_i (raddr_reached_i),
    .raddr_ack_i     (raddr_ack_i),
    .ramp_start_o    (ramp_start_o),
    .blk_done_o      (blk_done_o),
    .blk_addr_o      (blk_addr_o),
    .done_o          (done_o),
    .aborted_o       (aborted_o),
    .timeout_o       (timeout_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [8:0] s, input logic [8:0] c);
    req_start_i = s;
    req_count_i = c;
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
  endtask

  // Responder: reached from strobe age reach_dly on, ack pulse at age ack_dly.
  // Optional one-cycle abort when address abort_addr is at age abort_age.
  task automatic run_resp(input int ncyc, input int reach_dly, input int ack_dly,
                          input int abort_addr, input int abort_age);
    int         age;
    logic       prev_stb;
    logic [8:0] prev_addr;
    obs_ramp = 0; obs_ramp_cyc = -1; obs_blk = 0; obs_blk_cyc = -1;
    obs_done = 0; obs_done_cyc = -1; obs_ready_cyc = -1;
    obs_stb_rise = 0; obs_nsaddr = 0;
    for (int i = 0; i < 8; i++) begin
      obs_baddr[i] = 9'd0;
      obs_saddr[i] = 9'd0;
    end
    prev_stb  = raddr_stb_o;
    prev_addr = raddr_o;
    age        = raddr_stb_o ? 1 : 0;
    obs_stb_hi = raddr_stb_o ? 1 : 0;
    if (raddr_stb_o) begin
      obs_saddr[0] = raddr_o;
      obs_nsaddr   = 1;
    end
    for (int c = 1; c <= ncyc; c++) begin
      raddr_reached_i = raddr_stb_o && (age >= reach_dly);
      raddr_ack_i     = raddr_stb_o && (age == ack_dly);
      abort_i         = (abort_addr >= 0) && raddr_stb_o &&
                        (raddr_o == 9'(abort_addr)) && (age == abort_age);
      step();
      if (ramp_start_o) begin
        if (obs_ramp_cyc < 0) obs_ramp_cyc = c;
        obs_ramp++;
      end
      if (blk_done_o) begin
        if (obs_blk_cyc < 0) obs_blk_cyc = c;
        if (obs_blk < 8) obs_baddr[obs_blk] = blk_addr_o;
        obs_blk++;
      end
      if (done_o) begin
        if (obs_done_cyc < 0) obs_done_cyc = c;
        obs_done++;
      end
      if (req_ready_o && (obs_ready_cyc < 0)) obs_ready_cyc = c;
      if (raddr_stb_o) obs_stb_hi++;
      if (raddr_stb_o && !prev_stb) obs_stb_rise++;
      if (raddr_stb_o && (!prev_stb || (raddr_o != prev_addr))) begin
        age = 1;
        if (obs_nsaddr < 8) obs_saddr[obs_nsaddr] = raddr_o;
        obs_nsaddr++;
      end else if (raddr_stb_o) begin
        age++;
      end else begin
        age = 0;
      end
      prev_stb  = raddr_stb_o;
      prev_addr = raddr_o;
    end
    raddr_reached_i = 1'b0;
    raddr_ack_i     = 1'b0;
    abort_i         = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; req_start_i = 9'd0; req_count_i = 9'd0; req_valid_i = 1'b0;
    abort_i = 1'b0; raddr_reached_i = 1'b0; raddr_ack_i = 1'b0;
    step(); step();
    n_tests++;
    if ({raddr_stb_o, ramp_start_o, blk_done_o, done_o, aborted_o, timeout_o, req_ready_o,
         raddr_o, blk_addr_o} !== {7'b0000001, 9'd0, 9'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got stb=%0b ramp=%0b bd=%0b done=%0b ab=%0b to=%0b rdy=%0b addr=%0d baddr=%0d expected 0/0/0/0/0/0/1/0/0",
               raddr_stb_o, ramp_start_o, blk_done_o, done_o, aborted_o, timeout_o, req_ready_o, raddr_o, blk_addr_o);
    end
    rst_n_i = 1'b1;
    step();
    n_tests++;
    if ({req_ready_o, raddr_stb_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: got rdy/stb=%b expected 10", {req_ready_o, raddr_stb_o});
    end
  endtask

  task automatic test_single_block();
    issue(9'd5, 9'd0);
    n_tests++;
    if ({raddr_stb_o, req_ready_o, raddr_o} !== {2'b10, 9'd5}) begin
      n_fail++;
      $display("FAIL single_accept: got stb=%0b rdy=%0b addr=%0d expected 1 0 5", raddr_stb_o, req_ready_o, raddr_o);
    end
    run_resp(30, 4, 14, -1, 0);
    n_tests++;
    if ({obs_ramp, obs_ramp_cyc} !== {32'd1, 32'd4}) begin
      n_fail++;
      $display("FAIL single_ramp: got count=%0d cyc=%0d expected 1 4", obs_ramp, obs_ramp_cyc);
    end
    n_tests++;
    if ({obs_blk, obs_blk_cyc, 23'd0, obs_baddr[0]} !== {32'd1, 32'd14, 32'd5}) begin
      n_fail++;
      $display("FAIL single_blk: got count=%0d cyc=%0d addr=%0d expected 1 14 5", obs_blk, obs_blk_cyc, obs_baddr[0]);
    end
    n_tests++;
    if ({obs_done, obs_done_cyc, obs_ready_cyc} !== {32'd1, 32'd15, 32'd16}) begin
      n_fail++;
      $display("FAIL single_done: got count=%0d cyc=%0d ready_cyc=%0d expected 1 15 16", obs_done, obs_done_cyc, obs_ready_cyc);
    end
    n_tests++;
    if ({aborted_o, timeout_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_flags: got %b expected 00", {aborted_o, timeout_o});
    end
  endtask

  task automatic test_wrap();
    issue(9'd510, 9'd2);
    run_resp(20, 2, 4, -1, 0);
    n_tests++;
    if ({obs_nsaddr, 5'd0, obs_saddr[0], obs_saddr[1], obs_saddr[2]} !== {32'd3, 5'd0, 9'd510, 9'd511, 9'd0}) begin
      n_fail++;
      $display("FAIL wrap_raddr_seq: got n=%0d %0d %0d %0d expected 3 510 511 0", obs_nsaddr, obs_saddr[0], obs_saddr[1], obs_saddr[2]);
    end
    n_tests++;
    if ({obs_blk, 5'd0, obs_baddr[0], obs_baddr[1], obs_baddr[2]} !== {32'd3, 5'd0, 9'd510, 9'd511, 9'd0}) begin
      n_fail++;
      $display("FAIL wrap_blk_addr: got n=%0d %0d %0d %0d expected 3 510 511 0", obs_blk, obs_baddr[0], obs_baddr[1], obs_baddr[2]);
    end
    n_tests++;
    if ({obs_ramp, obs_stb_hi, obs_stb_rise} !== {32'd3, 32'd12, 32'd0}) begin
      n_fail++;
      $display("FAIL wrap_strobe: got ramps=%0d stb_hi=%0d rises=%0d expected 3 12 0", obs_ramp, obs_stb_hi, obs_stb_rise);
    end
    n_tests++;
    if ({obs_done, obs_done_cyc} !== {32'd1, 32'd13}) begin
      n_fail++;
      $display("FAIL wrap_done: got count=%0d cyc=%0d expected 1 13", obs_done, obs_done_cyc);
    end
  endtask

  task automatic test_abort();
    issue(9'd20, 9'd7);
    run_resp(20, 3, 5, 21, 1);
    n_tests++;
    if ({obs_blk, obs_nsaddr, 14'd0, obs_baddr[0], obs_baddr[1]} !== {32'd2, 32'd2, 14'd0, 9'd20, 9'd21}) begin
      n_fail++;
      $display("FAIL abort_blocks: got blks=%0d strobes=%0d a0=%0d a1=%0d expected 2 2 20 21", obs_blk, obs_nsaddr, obs_baddr[0], obs_baddr[1]);
    end
    n_tests++;
    if ({obs_done, obs_done_cyc, obs_ready_cyc} !== {32'd1, 32'd11, 32'd12}) begin
      n_fail++;
      $display("FAIL abort_done: got count=%0d cyc=%0d ready_cyc=%0d expected 1 11 12", obs_done, obs_done_cyc, obs_ready_cyc);
    end
    n_tests++;
    if ({aborted_o, timeout_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL abort_flags: got ab/to=%b expected 10", {aborted_o, timeout_o});
    end
  endtask

  task automatic test_timeout();
    issue(9'd300, 9'd1);
    run_resp(30, 2, 1000, -1, 0);
    n_tests++;
    if ({obs_stb_hi, obs_blk, obs_ramp} !== {32'd16, 32'd0, 32'd1}) begin
      n_fail++;
      $display("FAIL timeout_strobe: got stb_hi=%0d blks=%0d ramps=%0d expected 16 0 1", obs_stb_hi, obs_blk, obs_ramp);
    end
    n_tests++;
    if ({obs_done, obs_done_cyc, 30'd0, timeout_o, aborted_o} !== {32'd1, 32'd17, 32'd2}) begin
      n_fail++;
      $display("FAIL timeout_done: got done=%0d cyc=%0d to=%0b ab=%0b expected 1 17 1 0", obs_done, obs_done_cyc, timeout_o, aborted_o);
    end
    issue(9'd7, 9'd0);
    n_tests++;
    if ({timeout_o, aborted_o, raddr_stb_o} !== 3'b001) begin
      n_fail++;
      $display("FAIL timeout_clear: got to/ab/stb=%b expected 001", {timeout_o, aborted_o, raddr_stb_o});
    end
    run_resp(10, 1, 2, -1, 0);
    n_tests++;
    if ({obs_blk, obs_done, 23'd0, obs_baddr[0], obs_blk_cyc} !== {32'd1, 32'd1, 32'd7, 32'd2}) begin
      n_fail++;
      $display("FAIL timeout_next_req: got blks=%0d done=%0d addr=%0d cyc=%0d expected 1 1 7 2", obs_blk, obs_done, obs_baddr[0], obs_blk_cyc);
    end
  endtask

  task automatic test_ack_vs_timeout();
    issue(9'd40, 9'd1);
    run_resp(40, 2, 16, -1, 0);
    n_tests++;
    if ({obs_blk, 14'd0, obs_baddr[0], obs_baddr[1], obs_stb_hi} !== {32'd2, 14'd0, 9'd40, 9'd41, 32'd32}) begin
      n_fail++;
      $display("FAIL corner_blocks: got blks=%0d a0=%0d a1=%0d stb_hi=%0d expected 2 40 41 32", obs_blk, obs_baddr[0], obs_baddr[1], obs_stb_hi);
    end
    n_tests++;
    if ({obs_done, 31'd0, timeout_o} !== {32'd1, 32'd0}) begin
      n_fail++;
      $display("FAIL corner_flags: got done=%0d to=%0b expected 1 0", obs_done, timeout_o);
    end
  endtask

  task automatic test_reset_mid();
    issue(9'd100, 9'd3);
    run_resp(6, 2, 50, -1, 0);
    #2;
    rst_n_i = 1'b0;
    #1;
    n_tests++;
    if ({raddr_stb_o, ramp_start_o, blk_done_o, done_o, aborted_o, timeout_o, req_ready_o,
         raddr_o, blk_addr_o} !== {7'b0000001, 9'd0, 9'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_async: got stb=%0b ramp=%0b bd=%0b done=%0b ab=%0b to=%0b rdy=%0b addr=%0d expected 0/0/0/0/0/0/1/0",
               raddr_stb_o, ramp_start_o, blk_done_o, done_o, aborted_o, timeout_o, req_ready_o, raddr_o);
    end
    step(); step();
    #2;
    rst_n_i = 1'b1;
    step();
    n_tests++;
    if ({req_ready_o, raddr_stb_o, raddr_o} !== {2'b10, 9'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_release: got rdy=%0b stb=%0b addr=%0d expected 1 0 0", req_ready_o, raddr_stb_o, raddr_o);
    end
    issue(9'd9, 9'd0);
    n_tests++;
    if ({raddr_stb_o, raddr_o} !== {1'b1, 9'd9}) begin
      n_fail++;
      $display("FAIL reset_mid_reaccept: got stb=%0b addr=%0d expected 1 9", raddr_stb_o, raddr_o);
    end
    run_resp(10, 1, 2, -1, 0);
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_wrap();
    test_abort();
    test_timeout();
    test_ack_vs_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
